mult_div_unit: RTL and testbench

- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes rs/rt operands and the decoded MD op from the E-stage pipeline register outputs, after forwarding.
- Drives Busy to the hazard unit, which stalls D and bubbles E while Busy is high or while a new MD op is starting.
- HI/LO read data feeds the E-stage result mux for mfhi/mflo.

---
 rtl/mult_div_unit_pkg.sv | 38 +++
 rtl/md_result_calc.sv | 50 +++++
 rtl/mult_div_unit.sv | 85 ++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and op-class decoders.
// MD_MADD_EN enables the multiply-accumulate op family.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int unsigned MdMultCyclesDefault = 5;
  localparam int unsigned MdDivCyclesDefault  = 10;

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_multi(input logic [3:0] op);
    logic w_multi;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: w_multi = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: w_multi = 1'b1;
`endif
      default: w_multi = 1'b0;
    endcase
    return w_multi;
  endfunction

endpackage

// File: rtl/md_result_calc.sv
// Combinational 64-bit {HI,LO} result generator for the latched MD operation.
// MD_MADD_EN adds the accumulate/subtract forms against the current HI/LO.
module md_result_calc
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [63:0] w_acc;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;

  always_comb begin
    w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    w_uprod = {32'b0, i_a} * {32'b0, i_b};
    w_acc   = {i_hi, i_lo};
    w_squot = 32'sd0;
    w_srem  = 32'sd0;
    if (i_b != 32'd0) begin
      w_squot = $signed(i_a) / $signed(i_b);
      w_srem  = $signed(i_a) % $signed(i_b);
    end
  end

  // Anything without a defined result (incl. divide by zero) returns HI/LO unchanged.
  always_comb begin
    o_res = w_acc;
    case (i_op)
      MD_MULT:  o_res = w_sprod;
      MD_MULTU: o_res = w_uprod;
      MD_DIV:   if (i_b != 32'd0) o_res = {w_srem, w_squot};
      MD_DIVU:  if (i_b != 32'd0) o_res = {i_a % i_b, i_a / i_b};
`ifdef MD_MADD_EN
      MD_MADD:  o_res = w_acc + w_sprod;
      MD_MADDU: o_res = w_acc + w_uprod;
      MD_MSUB:  o_res = w_acc - w_sprod;
      MD_MSUBU: o_res = w_acc - w_uprod;
`endif
      default:  o_res = w_acc;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit holding architectural HI/LO; Busy drives the hazard unit.
// MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU as MULT_CYCLES operations.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MdMultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = MdDivCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_mthi;
  logic        w_mtlo;
  logic [63:0] w_res;

  always_comb begin
    w_accept = Start && !r_busy && md_is_multi(Op);
    w_mthi   = Start && !r_busy && (Op == MD_MTHI);
    w_mtlo   = Start && !r_busy && (Op == MD_MTLO);
  end

  md_result_calc u_calc (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
      r_op   <= MD_NONE;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op   <= Op;
        r_a    <= A;
        r_b    <= B;
        r_cnt  <= md_is_div(Op) ? DivCnt : MultCnt;
        r_busy <= 1'b1;
      end else if (r_cnt != 4'd0) begin
        // Last busy cycle: commit the result as Busy drops.
        r_cnt  <= r_cnt - 4'd1;
        r_busy <= (r_cnt != 4'd1);
        if (r_cnt == 4'd1) begin
          r_hi <= w_res[63:32];
          r_lo <= w_res[31:0];
        end
      end
      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against a
// transaction-level model of HI/LO and Busy duration.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result per architectural rules, as {HI,LO}.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb;
    longint unsigned ua64, ub64;
    logic [31:0] ua, ub, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua64 * ub64;
      MD_DIVU:  return (b == 0) ? {hi, lo} : {a % b, a / b};
      MD_DIV: begin
        if (b == 0) return {hi, lo};
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        q = ua / ub;
        r = ua % ub;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
      end
`ifdef MD_MADD_EN
      MD_MADD:  return {hi, lo} + 64'(sa * sb);
      MD_MADDU: return {hi, lo} + ua64 * ub64;
      MD_MSUB:  return {hi, lo} - 64'(sa * sb);
      MD_MSUBU: return {hi, lo} - ua64 * ub64;
`endif
      default:  return {hi, lo};
    endcase
  endfunction

  task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit toggle, input bit inject_mt);
    logic [63:0] exp;
    int busy_cnt;
    int n_exp;
    exp = model(op, a, b, m_hi, m_lo);
    n_exp = (op == MD_DIV || op == MD_DIVU) ? DivN : MultN;
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; Op = MD_NONE;
    if (inject_mt) begin
      Start = 1'b1; Op = MD_MTLO; A = 32'h0000_DEAD;
    end
    busy_cnt = 0;
    for (int i = 0; i < 40 && Busy; i++) begin
      busy_cnt++;
      if (inject_mt && i == 1) check_eq({tag, "_lo_during_busy"}, {32'd0, LO}, {32'd0, m_lo});
      if (toggle) begin
        A = $urandom; B = $urandom;
      end
      @(negedge clk);
      Start = 1'b0; Op = MD_NONE;
    end
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n_exp));
    check_eq({tag, "_hilo"}, {HI, LO}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    Start = 1'b1; Op = op; A = a; B = $urandom;
    @(negedge clk);
    Start = 1'b0; Op = MD_NONE;
    if (op == MD_MTHI) m_hi = a;
    if (op == MD_MTLO) m_lo = a;
    check_eq({tag, "_busy"}, {63'd0, Busy}, 64'd0);
    check_eq({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [31:0] a, b;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
    reset = 1'b1; Start = 1'b0; Op = MD_NONE; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", {63'd0, Busy}, 64'd0);
    check_eq("reset_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    run_multi("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_multi("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    run_multi("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_multi("divu", MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
    run_single("mthi", MD_MTHI, 32'h1234_5678);
    run_multi("div0", MD_DIV, 32'h0000_0042, 32'd0, 1'b0, 1'b0);
    run_multi("mult_mtlo_ignored", MD_MULT, 32'h0001_0003, 32'h0000_0101, 1'b0, 1'b1);
    run_single("nop_none", MD_NONE, 32'hAAAA_5555);
    run_single("nop_undef", 4'd13, 32'h5555_AAAA);
`ifdef MD_MADD_EN
    run_multi("madd", MD_MADD, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    run_multi("msubu", MD_MSUBU, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
`else
    run_single("madd_undef", MD_MADD, 32'h0BAD_0BAD);
    run_single("msubu_undef", MD_MSUBU, 32'h0BAD_0BAD);
`endif

    // Reset during the 4th busy cycle of a divide discards it.
    @(negedge clk);
    Start = 1'b1; Op = MD_DIV; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; Op = MD_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_mid_busy", {63'd0, Busy}, 64'd0);
    check_eq("rst_mid_hilo", {HI, LO}, 64'd0);
    repeat (12) @(negedge clk);
    check_eq("rst_no_late_write", {HI, LO}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      if (op == MD_MTHI || op == MD_MTLO) run_single("rand_mt", op, a);
      else run_multi("rand_md", op, a, b, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
